// File: rtl/vga_scan_out_if.sv
// Framebuffer read port and VGA pin bundle between vga_scan_out and its neighbours.
interface vga_scan_out_if;
    logic [11:0] x;
    logic [11:0] y;
    logic [5:0]  rgb_data;
    logic        vga_h_out;
    logic        vga_v_out;
    logic [11:0] vga_data;
    logic        frame_start;

    modport master (
        output x, y, vga_h_out, vga_v_out, vga_data, frame_start,
        input  rgb_data
    );

    modport slave (
        input  x, y, vga_h_out, vga_v_out, vga_data, frame_start,
        output rgb_data
    );
endinterface

// File: rtl/vga_scan_out.sv
// Raster timing generator and RGB222->RGB444 pixel stage for the snake framebuffer.
// Sync and data leave through the same RD_LAT+1 pixel-period pipeline so they stay aligned.
module vga_scan_out #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1,
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    vga_scan_out_if.master bus
);
    localparam int unsigned CW      = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic        HS_ON   = 1'(HS_POL);
    localparam logic        VS_ON   = 1'(VS_POL);

    logic [DW-1:0]     div;
    logic              pe;
    logic [CW-1:0]     h;
    logic [CW-1:0]     v;
    logic              h_last;
    logic              v_last;
    logic              act;
    logic              hs;
    logic              vs;
    logic [RD_LAT-1:0] act_sr;
    logic [RD_LAT-1:0] hs_sr;
    logic [RD_LAT-1:0] vs_sr;

    function automatic logic [11:0] expand(input logic [5:0] c);
        return {c[5:4], c[5:4], c[3:2], c[3:2], c[1:0], c[1:0]};
    endfunction

    // Pixel enable: with PIX_DIV=1 div is pinned at 0 and pe is always high.
    assign pe = (div == DW'(PIX_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div <= '0;
        end else if (pe) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign h_last = (h == CW'(H_TOTAL - 1));
    assign v_last = (v == CW'(V_TOTAL - 1));

    // Raster position counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + CW'(1);
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    // Stage-0 decode straight from the counters.
    assign act = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
    assign hs  = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs  = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));

    // Read address clamps to 0 in blanking so it never leaves the framebuffer.
    assign bus.x = (h < CW'(H_ACTIVE)) ? h : '0;
    assign bus.y = (v < CW'(V_ACTIVE)) ? v : '0;

    // Delay line matching the framebuffer read latency; newest bit at index 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else if (pe) begin
            act_sr <= RD_LAT'({act_sr, act});
            hs_sr  <= RD_LAT'({hs_sr, hs});
            vs_sr  <= RD_LAT'({vs_sr, vs});
        end
    end

    // Pin register; frame_start is a single CLK pulse after the wrap edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.vga_data    <= '0;
            bus.vga_h_out   <= ~HS_ON;
            bus.vga_v_out   <= ~VS_ON;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= pe && h_last && v_last;
            if (pe) begin
                bus.vga_data  <= act_sr[RD_LAT-1] ? expand(bus.rgb_data) : 12'h000;
                bus.vga_h_out <= hs_sr[RD_LAT-1] ? HS_ON : ~HS_ON;
                bus.vga_v_out <= vs_sr[RD_LAT-1] ? VS_ON : ~VS_ON;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a reduced raster: instance A (PIX_DIV=2, RD_LAT=1), instance B (PIX_DIV=1, RD_LAT=2).
module tb_vga_scan_out;
    localparam int HA = 16, HF = 2, HSW = 3, HB = 2, HT = HA + HF + HSW + HB;
    localparam int VA = 8,  VF = 1, VSW = 2, VB = 1, VT = VA + VF + VSW + VB;

    typedef struct packed {
        logic [11:0] data;
        logic        hs;
        logic        vs;
        logic [11:0] ch;
        logic [11:0] cv;
    } exp_t;

    logic clk = 1'b0;
    logic rst [2];
    int   total = 0;
    int   bad = 0;
    exp_t sbq [$];

    logic       ovr = 1'b0;
    logic [5:0] ovr_val = 6'h00;

    vga_scan_out_if ifa ();
    vga_scan_out_if ifb ();

    vga_scan_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .HS_POL(1), .VS_POL(1), .PIX_DIV(2), .RD_LAT(1))
        dut_a (.CLK(clk), .RESET(rst[0]), .bus(ifa.master));

    vga_scan_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .HS_POL(1), .VS_POL(1), .PIX_DIV(1), .RD_LAT(2))
        dut_b (.CLK(clk), .RESET(rst[1]), .bus(ifb.master));

    always #5 clk = ~clk;

    function automatic int pdiv(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int rlat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    logic [11:0] o_x [2], o_y [2], o_data [2];
    logic        o_hs [2], o_vs [2], o_fs [2];
    logic [5:0]  rgb [2];
    logic [5:0]  rd_pipe [2][3];

    always_comb begin
        o_x[0] = ifa.x;  o_y[0] = ifa.y;  o_data[0] = ifa.vga_data;
        o_hs[0] = ifa.vga_h_out; o_vs[0] = ifa.vga_v_out; o_fs[0] = ifa.frame_start;
        o_x[1] = ifb.x;  o_y[1] = ifb.y;  o_data[1] = ifb.vga_data;
        o_hs[1] = ifb.vga_h_out; o_vs[1] = ifb.vga_v_out; o_fs[1] = ifb.frame_start;
    end

    always_comb begin
        for (int k = 0; k < 2; k++)
            rgb[k] = ovr ? ovr_val : rd_pipe[k][rlat(k) - 1];
    end

    assign ifa.rgb_data = rgb[0];
    assign ifb.rgb_data = rgb[1];

    // Reference raster and framebuffer model with RD_LAT pixel-period read latency.
    int  m_div [2], m_h [2], m_v [2], p_h [2], p_v [2];
    bit  m_pe [2], p_pe [2], fs_exp [2];

    always_comb begin
        for (int k = 0; k < 2; k++)
            m_pe[k] = (m_div[k] == pdiv(k) - 1);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_div[k] <= 0; m_h[k] <= 0; m_v[k] <= 0;
                p_pe[k] <= 1'b0; fs_exp[k] <= 1'b0;
            end else begin
                p_pe[k]   <= m_pe[k];
                p_h[k]    <= m_h[k];
                p_v[k]    <= m_v[k];
                fs_exp[k] <= m_pe[k] && (m_h[k] == HT - 1) && (m_v[k] == VT - 1);
                m_div[k]  <= m_pe[k] ? 0 : m_div[k] + 1;
                if (m_pe[k]) begin
                    if (m_h[k] == HT - 1) begin
                        m_h[k] <= 0;
                        m_v[k] <= (m_v[k] == VT - 1) ? 0 : m_v[k] + 1;
                    end else begin
                        m_h[k] <= m_h[k] + 1;
                    end
                    rd_pipe[k][0] <= 6'(o_x[k] + o_y[k]);
                    rd_pipe[k][1] <= rd_pipe[k][0];
                    rd_pipe[k][2] <= rd_pipe[k][1];
                end
            end
        end
    end

    function automatic exp_t ref_pins(input int h, input int v);
        exp_t e;
        logic [5:0] f;
        f = 6'(h + v);
        e.ch = 12'(h);
        e.cv = 12'(v);
        e.data = (h < HA && v < VA) ? {4'(f[5:4] * 5), 4'(f[3:2] * 5), 4'(f[1:0] * 5)} : 12'h000;
        e.hs = (h >= HA + HF) && (h < HA + HF + HSW);
        e.vs = (v >= VA + VF) && (v < VA + VF + VSW);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int k, input int n);
        rst[k] = 1'b1;
        repeat (n) tick();
        rst[k] = 1'b0;
    endtask

    task automatic wait_level(input int k, input bit use_v, input logic lvl, inout int cnt, input int limit);
        logic s;
        s = use_v ? o_vs[k] : o_hs[k];
        while (s !== lvl && cnt < limit) begin
            tick();
            cnt++;
            s = use_v ? o_vs[k] : o_hs[k];
        end
    endtask

    task automatic test_reset();
        int  cnt;
        bit  found;
        rst[0] = 1'b1;
        repeat (5) tick();
        total++;
        if (o_data[0] !== 12'h000 || o_hs[0] !== 1'b0 || o_vs[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_pins: data=%h hs=%b vs=%b want 000 0 0", o_data[0], o_hs[0], o_vs[0]);
        end
        total++;
        if (o_x[0] !== 12'd0 || o_y[0] !== 12'd0) begin
            bad++;
            $display("FAIL reset_xy: x=%0d y=%0d want 0 0", o_x[0], o_y[0]);
        end
        total++;
        if (o_fs[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_fs: got %b want 0", o_fs[0]);
        end
        rst[0] = 1'b0;
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 2 * 2 * HT * VT) begin
            tick();
            cnt++;
            if (o_fs[0] === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || cnt != 2 * HT * VT) begin
            bad++;
            $display("FAIL first_frame_start: at %0d clk (found=%0d) want %0d", cnt, found, 2 * HT * VT);
        end
        tick();
        total++;
        if (o_fs[0] !== 1'b0) begin
            bad++;
            $display("FAIL frame_start_width: still %b one clk later, want 0", o_fs[0]);
        end
    endtask

    task automatic test_sync(input int k, input bit use_v);
        int cnt, r1, f1, r2, lim, exp_r1, exp_w, exp_p;
        apply_reset(k, 2);
        cnt = 0;
        lim = 3 * pdiv(k) * HT * VT;
        wait_level(k, use_v, 1'b1, cnt, lim); r1 = cnt;
        wait_level(k, use_v, 1'b0, cnt, lim); f1 = cnt;
        wait_level(k, use_v, 1'b1, cnt, lim); r2 = cnt;
        exp_r1 = use_v ? pdiv(k) * ((VA + VF) * HT + 1 + rlat(k)) : pdiv(k) * (HA + HF + 1 + rlat(k));
        exp_w  = use_v ? pdiv(k) * VSW * HT : pdiv(k) * HSW;
        exp_p  = use_v ? pdiv(k) * HT * VT : pdiv(k) * HT;
        total++;
        if (r1 != exp_r1) begin
            bad++;
            $display("FAIL sync_first_rise dut%0d v=%0d: %0d clk want %0d", k, use_v, r1, exp_r1);
        end
        total++;
        if (f1 - r1 != exp_w) begin
            bad++;
            $display("FAIL sync_width dut%0d v=%0d: %0d clk want %0d", k, use_v, f1 - r1, exp_w);
        end
        total++;
        if (r2 - r1 != exp_p) begin
            bad++;
            $display("FAIL sync_period dut%0d v=%0d: %0d clk want %0d", k, use_v, r2 - r1, exp_p);
        end
    endtask

    task automatic test_data_frame(input int k);
        exp_t e;
        int   n;
        apply_reset(k, 2);
        sbq.delete();
        e = '0;
        for (int i = 0; i < rlat(k); i++) sbq.push_back(e);
        n = pdiv(k) * HT * (VT + 2);
        for (int c = 0; c < n; c++) begin
            tick();
            total++;
            if (o_x[k] !== 12'((m_h[k] < HA) ? m_h[k] : 0) || o_y[k] !== 12'((m_v[k] < VA) ? m_v[k] : 0)) begin
                bad++;
                $display("FAIL read_addr dut%0d h=%0d v=%0d: x=%0d y=%0d", k, m_h[k], m_v[k], o_x[k], o_y[k]);
            end
            total++;
            if (o_fs[k] !== fs_exp[k]) begin
                bad++;
                $display("FAIL frame_start dut%0d clk %0d: got %b want %b", k, c, o_fs[k], fs_exp[k]);
            end
            if (p_pe[k]) begin
                sbq.push_back(ref_pins(p_h[k], p_v[k]));
                e = sbq.pop_front();
                total++;
                if ({o_data[k], o_hs[k], o_vs[k]} !== {e.data, e.hs, e.vs}) begin
                    bad++;
                    $display("FAIL pixel dut%0d (%0d,%0d): data=%h hs=%b vs=%b want %h %b %b",
                             k, e.ch, e.cv, o_data[k], o_hs[k], o_vs[k], e.data, e.hs, e.vs);
                end
                if (e.ch == 12'(HA - 1) && e.cv == 12'(VA - 1)) begin
                    total++;
                    if (o_data[k] === 12'h000) begin
                        bad++;
                        $display("FAIL corner_driven dut%0d: data=%h want nonzero", k, o_data[k]);
                    end
                end
                if (e.ch == 12'(HA) && e.cv == 12'(VA - 1)) begin
                    total++;
                    if (o_data[k] !== 12'h000) begin
                        bad++;
                        $display("FAIL past_edge_black dut%0d: data=%h want 000", k, o_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_expand();
        apply_reset(0, 2);
        ovr = 1'b1;
        ovr_val = 6'b10_01_11;
        repeat (6) tick();
        total++;
        if (o_data[0] !== 12'hA5F) begin
            bad++;
            $display("FAIL expand_a5f: got %h want A5F", o_data[0]);
        end
        ovr_val = 6'h03;
        repeat (2) tick();
        total++;
        if (o_data[0] !== 12'h00F) begin
            bad++;
            $display("FAIL expand_00f: got %h want 00F", o_data[0]);
        end
        repeat (28) tick();
        total++;
        if (o_data[0] !== 12'h000) begin
            bad++;
            $display("FAIL blank_ignores_rgb: got %h want 000", o_data[0]);
        end
        ovr = 1'b0;
    endtask

    task automatic test_mid_reset(input int k);
        int  cnt;
        bit  found;
        apply_reset(k, 2);
        cnt = 0;
        while (!(m_h[k] == 10 && m_v[k] == 5) && cnt < 2 * pdiv(k) * HT * VT) begin
            tick();
            cnt++;
        end
        total++;
        if (o_data[k] === 12'h000) begin
            bad++;
            $display("FAIL mid_frame_active dut%0d: data=%h want nonzero before reset", k, o_data[k]);
        end
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
        total++;
        if (o_x[k] !== 12'd0 || o_y[k] !== 12'd0 || o_data[k] !== 12'h000 ||
            o_hs[k] !== 1'b0 || o_vs[k] !== 1'b0 || o_fs[k] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset dut%0d: x=%0d y=%0d data=%h hs=%b vs=%b fs=%b want all 0",
                     k, o_x[k], o_y[k], o_data[k], o_hs[k], o_vs[k], o_fs[k]);
        end
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 2 * pdiv(k) * HT * VT) begin
            tick();
            cnt++;
            if (o_fs[k] === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || cnt != pdiv(k) * HT * VT) begin
            bad++;
            $display("FAIL restart_frame_start dut%0d: at %0d clk (found=%0d) want %0d", k, cnt, found, pdiv(k) * HT * VT);
        end
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        test_reset();
        test_sync(0, 1'b0);
        test_sync(0, 1'b1);
        test_data_frame(0);
        test_expand();
        test_mid_reset(0);
        test_sync(1, 1'b0);
        test_sync(1, 1'b1);
        test_data_frame(1);
        test_mid_reset(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
